// File: rtl/ring_pkg.sv
// Shared definitions for the ring router input path: packet geometry,
// packet field positions, port encodings and the input buffer FSM states.
package ring_pkg;

   localparam int unsigned PACKET_SIZE = 49;

   // Packet field positions
   localparam int unsigned DEST_LSB   = 0;
   localparam int unsigned DEST_MSB   = 15;
   localparam int unsigned TS_LSB_BIT = 32;

   // Input port encodings carried on port_id
   localparam logic [1:0] PORT_LOCAL = 2'b00;
   localparam logic [1:0] PORT_EAST  = 2'b01;
   localparam logic [1:0] PORT_WEST  = 2'b10;

   // Credit handshake phases: INIT hands out the initial allotment,
   // RUN returns one credit per dequeue.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ibuf_state_e;

endpackage

// File: rtl/ring_input_buffer_if.sv
// Handshake bundle between the upstream link, the input buffer and the
// route computation / switch stage. The slave modport is the buffer side.
interface ring_input_buffer_if #(
   parameter int unsigned PACKET_SIZE = ring_pkg::PACKET_SIZE
);

   logic                   in_valid;
   logic [PACKET_SIZE-1:0] in_data;
   logic                   in_credit;
   logic                   head_valid;
   logic [PACKET_SIZE-1:0] head_data;
   logic                   route_update_en;
   logic                   deq;

   modport master (
      output in_valid, in_data, deq,
      input  in_credit, head_valid, head_data, route_update_en
   );

   modport slave (
      input  in_valid, in_data, deq,
      output in_credit, head_valid, head_data, route_update_en
   );

endinterface

// File: rtl/ring_fifo_mem.sv
// DEPTH x PACKET_SIZE register array with one synchronous write port and
// one asynchronous read port. Holds data only, so it carries no reset.
module ring_fifo_mem #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned PACKET_SIZE = ring_pkg::PACKET_SIZE,
   parameter int unsigned AW          = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [PACKET_SIZE-1:0] wr_data,
   input  logic [AW-1:0]          rd_addr,
   output logic [PACKET_SIZE-1:0] rd_data
);

   logic [PACKET_SIZE-1:0] mem [DEPTH];

   // Write the incoming packet into its slot
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ring_input_buffer.sv
// Per-port input buffer of the ring router. Credit-flow-controlled FIFO
// that presents its head packet to route computation together with a
// one-cycle route_update_en strobe per new head, and returns one credit
// upstream per dequeue after handing out the initial DEPTH credits.
// Optional build macro: RING_IBUF_OVF_CHECK_EN -- when defined, a write
// that arrives while full (and is not covered by a same-cycle dequeue)
// sets the sticky ovf_err flag; otherwise such writes are dropped silently.
module ring_input_buffer #(
   parameter int unsigned PACKET_SIZE = ring_pkg::PACKET_SIZE,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned IN_PORT     = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   ring_input_buffer_if.slave        bus,
   output logic [$clog2(DEPTH):0]    count,
   output logic [1:0]                port_id,
   output logic                      ovf_err
);

   import ring_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   ibuf_state_e            state_q, state_d;
   logic [PW-1:0]          credit_cnt_q, credit_cnt_d;
   logic                   in_credit_q, in_credit_d;
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic                   head_new_q;
   logic                   empty, full;
   logic                   enq, deq_acc;
   logic [PW-1:0]          count_next;
   logic [PACKET_SIZE-1:0] rd_data;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
   // A dequeue on an empty FIFO is ignored; a write into a full FIFO is
   // only possible when the head leaves in the same cycle.
   assign deq_acc = bus.deq && !empty;
   assign enq     = bus.in_valid && (!full || deq_acc);

   assign count      = wr_ptr_q - rd_ptr_q;
   assign count_next = count + PW'(enq) - PW'(deq_acc);

   ring_fifo_mem #(
      .DEPTH       (DEPTH),
      .PACKET_SIZE (PACKET_SIZE),
      .AW          (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (enq),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (bus.in_data),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (rd_data)
   );

   // FSM state register together with the credit counter and credit pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         credit_cnt_q <= '0;
         in_credit_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_cnt_q <= credit_cnt_d;
         in_credit_q  <= in_credit_d;
      end
   end

   // Leave INIT once the DEPTH-th initial credit is being issued
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (credit_cnt_q == PW'(DEPTH - 1)) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // Credit pulse for the next cycle: every cycle in INIT, per dequeue in RUN
   always_comb begin
      in_credit_d  = 1'b0;
      credit_cnt_d = credit_cnt_q;
      case (state_q)
         ST_INIT: begin
            in_credit_d  = 1'b1;
            credit_cnt_d = credit_cnt_q + 1'b1;
         end
         ST_RUN:  in_credit_d = deq_acc;
         default: in_credit_d = 1'b0;
      endcase
   end

   // FIFO pointers and the new-head marker behind route_update_en
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         head_new_q <= 1'b0;
      end else begin
         if (enq)     wr_ptr_q <= wr_ptr_q + 1'b1;
         if (deq_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
         head_new_q <= (empty && enq) || (deq_acc && (count_next != '0));
      end
   end

`ifdef RING_IBUF_OVF_CHECK_EN
   logic ovf_q;

   // Sticky flag for a write dropped because the FIFO was full
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (bus.in_valid && full && !deq_acc) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf_err = ovf_q;
`else
   assign ovf_err = 1'b0;
`endif

   assign bus.in_credit       = in_credit_q;
   assign bus.head_valid      = !empty;
   // Stale storage is masked so the head bus reads zero while empty
   assign bus.head_data       = empty ? '0 : rd_data;
   assign bus.route_update_en = !empty && head_new_q;
   assign port_id             = 2'(IN_PORT);

endmodule
